mel_band_acc: RTL and testbench
===============================

Name: mel_band_acc

Overview:
- Upstream neighbour of the log stage in the MFCC pipeline.
- Consumes a stream of unsigned 32-bit power-spectrum bins, each paired with a Q1.15 triangular mel weight from the filterbank sequencer.
- Accumulates weight×power per mel band in fixed point.
- At band end, converts the sum to IEEE-754 float32 and issues it as a single-cycle valid pulse, shaped to drive the ln_float32 s_axis_a tvalid/tdata inputs directly (no back-pressure).

Parameters:
- NUM_BANDS, 26: mel bands per frame; out_band wraps after NUM_BANDS-1.
- ACC_W, 56: accumulator width in bits. Must be ≥ 49 and ≤ 64.
- ZERO_FLOOR, 32'h3380_0000: float32 emitted when the band sum is 0 (2^-24), so ln never sees 0.

Ports:
- hclk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_power  in  32  unsigned power bin.
- in_weight  in  16  unsigned Q1.15 mel weight (0x8000 = 1.0).
- in_last  in  1  final bin of the current band.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  32  float32 band energy.
- out_band  out  8  band index of out_data, 0..NUM_BANDS-1.
- out_frame_last  out  1  high with out_valid when out_band = NUM_BANDS-1.
- ovf_sticky  out  1  accumulator saturated since reset.

Behaviour:
- Interface: one clock, hclk; reset is asynchronous and active-low, rst_n.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_band=0, out_frame_last=0, ovf_sticky=0. Accumulator, pipeline valids and band counter are cleared.
- Reset mid-band discards the partial sum; the next band starts at index 0.
- Handshake: a beat is accepted on any cycle with in_valid && in_ready. in_valid is ignored while in_ready=0.
- Datapath pipeline:
  - P1: product = in_power × in_weight, 48 bits, registered with a valid flag and a last flag.
  - P2: acc += zero-extended product.
  - If the true sum exceeds 2^ACC_W-1, acc saturates at all-ones and ovf_sticky is set. Only reset clears ovf_sticky.
- FSM states:
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0; waits for the last product to reach acc.
  - NORM: in_ready=0; registers msb = index of the highest set bit of acc, plus a zero flag.
  - EMIT: in_ready=0; out_valid=1 for exactly one cycle.
- FSM transitions: ACCUM -> DRAIN on acceptance of a beat with in_last=1; DRAIN -> NORM -> EMIT -> ACCUM, one cycle each.
- Timing: last beat accepted at cycle T gives out_valid at T+4; in_ready is low T+1..T+4 and high again at T+5. This gives a minimum 5 cycles per band.
- Acc is cleared in EMIT, so the next band starts from 0.
- Float conversion, value = acc × 2^-15:
  - sign = 0.
  - exp = msb − 15 + 127.
  - mantissa = the 23 bits below msb. If msb < 23, left-justify with zero fill. If msb > 23, truncate toward zero (no rounding).
  - Zero acc emits ZERO_FLOOR.
  - Results are never denormal and never inf, because ACC_W ≤ 64 bounds exp to ≤ 175.
- out_data, out_band and out_frame_last hold their values between strobes.
- out_band increments after each EMIT and wraps from NUM_BANDS-1 to 0. out_frame_last is asserted only in the EMIT cycle of band NUM_BANDS-1.
- A single-beat band (in_last on the first beat) is legal.
- An in_last beat arriving in the same cycle as a saturating add still emits the saturated value.

Test Plan:
- Single beat: power=1, weight=0x8000, last=1 -> out_valid exactly 4 cycles after acceptance, out_data=0x3F800000, out_band=0.
- Two beats: (power=3, weight=0x4000) then (power=5, weight=0x8000, last) -> sum 6.5, out_data=0x40D00000. in_ready is 0 for 4 cycles after last, and beats offered in that window are not consumed.
- Zero band: power=0, weight=0x8000, last -> out_data=0x33800000. Also power=7, weight=0, last -> 0x33800000.
- Saturation, ACC_W=56: 257 beats of power=0xFFFFFFFF, weight=0xFFFF -> acc saturates to all-ones, ovf_sticky=1, out_data=0x53FFFFFF (truncated mantissa). Next band of power=1, weight=0x8000 gives 0x3F800000 with ovf_sticky still 1.
- Frame wrap: 27 single-beat bands -> out_band runs 0..25 then 0; out_frame_last=1 only on band 25.
- Reset mid-band: 3 beats accepted without last, assert rst_n=0 for 1 cycle. All outputs return to reset values immediately; next band power=2, weight=0x8000 -> out_data=0x40000000, out_band=0.

Source files
------------

// File: rtl/mel_band_acc.sv
// rtl/mel_band_acc.sv - per-band weighted power accumulator with float32 result strobe
module mel_band_acc #(
  parameter int          NUM_BANDS  = 26,
  parameter int          ACC_W      = 56,
  parameter logic [31:0] ZERO_FLOOR = 32'h3380_0000
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_power,
  input  logic [15:0] in_weight,
  input  logic        in_last,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [7:0]  out_band,
  output logic        out_frame_last,
  output logic        ovf_sticky
);

  localparam int MSB_W = $clog2(ACC_W);
  localparam logic [7:0] LAST_BAND = 8'(NUM_BANDS - 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, NORM, EMIT} state_t;

  state_t             state_q, state_d;
  logic               accept;
  logic [47:0]        prod_q;
  logic               p1_valid, p1_last;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum_c;
  logic [MSB_W-1:0]   msb_c, msb_q;
  logic               zero_q;
  logic [7:0]         band_cnt;
  logic [7:0]         exp_c;
  logic [22:0]        mant_c;

  // The strobe cycle also blocks input, so a band costs at least five cycles.
  assign in_ready = (state_q == ACCUM) && !out_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && in_last) state_d = DRAIN;
      DRAIN: if (p1_valid && p1_last) state_d = NORM;
      NORM:  state_d = EMIT;
      EMIT:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
    end else begin
      p1_valid <= accept;
      p1_last  <= accept && in_last;
      if (accept) prod_q <= {16'b0, in_power} * {32'b0, in_weight};
    end
  end

  assign sum_c = {1'b0, acc} + {{(ACC_W-47){1'b0}}, prod_q};

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (state_q == EMIT) begin
      acc <= '0;
    end else if (p1_valid) begin
      if (sum_c[ACC_W]) begin
        acc        <= '1;
        ovf_sticky <= 1'b1;
      end else begin
        acc <= sum_c[ACC_W-1:0];
      end
    end
  end

  always_comb begin
    msb_c = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (acc[i]) msb_c = MSB_W'(i);
    end
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      msb_q  <= '0;
      zero_q <= 1'b0;
    end else if (state_q == NORM) begin
      msb_q  <= msb_c;
      zero_q <= (acc == '0);
    end
  end

  // Shifting by msb puts the leading one at bit 23; the 23 bits beneath it
  // are the mantissa, zero-filled or truncated as the magnitude requires.
  assign exp_c  = 8'(msb_q) + 8'd112;
  assign mant_c = 23'({acc, 23'b0} >> msb_q);

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_band       <= '0;
      out_frame_last <= 1'b0;
      band_cnt       <= '0;
    end else if (state_q == EMIT) begin
      out_valid      <= 1'b1;
      out_data       <= zero_q ? ZERO_FLOOR : {1'b0, exp_c, mant_c};
      out_band       <= band_cnt;
      out_frame_last <= (band_cnt == LAST_BAND);
      band_cnt       <= (band_cnt == LAST_BAND) ? 8'd0 : band_cnt + 8'd1;
    end else begin
      out_valid      <= 1'b0;
      out_frame_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mel_band_acc.sv
// tb/tb_mel_band_acc.sv - directed bench with arithmetic band model for mel_band_acc
module tb_mel_band_acc;

  localparam int NB = 26;
  localparam logic [127:0] MAXV = (128'(1) << 56) - 128'(1);

  logic        hclk, rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_power;
  logic [15:0] in_weight;
  logic        out_valid, out_frame_last, ovf_sticky;
  logic [31:0] out_data;
  logic [7:0]  out_band;

  mel_band_acc dut (
    .hclk(hclk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_power(in_power),
    .in_weight(in_weight), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_band(out_band),
    .out_frame_last(out_frame_last), .ovf_sticky(ovf_sticky)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] to_f(input logic [127:0] s);
    int m;
    logic [127:0] mant;
    if (s == 0) return 32'h3380_0000;
    m = 0;
    while ((s >> (m + 1)) != 0) m++;
    mant = ((s << 23) / (128'(1) << m)) - (128'(1) << 23);
    return {1'b0, 8'(m + 112), mant[22:0]};
  endfunction

  initial begin
    hclk = 0;
    forever #5 hclk = ~hclk;
  end

  // Model state, advanced at the falling edge
  int           cyc = 0;
  int           m_acc_cyc = 0;
  logic [127:0] m_sum;
  logic         m_busy, m_ovf;
  logic [31:0]  m_pend, m_last_data;
  int           m_band, m_last_band;
  logic         exp_ready, exp_valid;
  int           emit_cnt = 0;
  logic [31:0]  seen_data;
  logic [7:0]   seen_band;
  logic         seen_fl, seen_ovf;
  int           seen_lat;

  always @(negedge hclk) begin
    if (!rst_n) begin
      m_sum = 0; m_busy = 0; m_ovf = 0; m_band = 0;
      m_last_data = 0; m_last_band = 0;
    end else begin
      exp_ready = !(m_busy && cyc > m_acc_cyc && cyc <= m_acc_cyc + 4);
      exp_valid = m_busy && (cyc == m_acc_cyc + 4);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("out_frame_last", out_frame_last, exp_valid && (m_band == NB - 1));
      if (exp_valid) begin
        chk("out_data", out_data, m_pend);
        chk("out_band", out_band, m_band);
        chk("ovf_sticky", ovf_sticky, m_ovf);
        m_last_data = m_pend;
        m_last_band = m_band;
        m_band = (m_band + 1) % NB;
        m_busy = 0;
      end else begin
        chk("out_data_hold", out_data, m_last_data);
        chk("out_band_hold", out_band, m_last_band);
      end
      if (out_valid) begin
        emit_cnt++;
        seen_data = out_data;
        seen_band = out_band;
        seen_fl   = out_frame_last;
        seen_ovf  = ovf_sticky;
        seen_lat  = cyc - m_acc_cyc;
      end
      if (in_valid && exp_ready) begin
        m_sum = m_sum + 128'(in_power) * 128'(in_weight);
        if (m_sum > MAXV) begin
          m_sum = MAXV;
          m_ovf = 1;
        end
        if (in_last) begin
          m_pend = to_f(m_sum);
          m_sum = 0;
          m_busy = 1;
          m_acc_cyc = cyc;
        end
      end
    end
    cyc++;
  end

  task automatic send_beat(input logic [31:0] p, input logic [15:0] w, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1; in_power = p; in_weight = w; in_last = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge hclk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge hclk);
    #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_emit(input int start);
    bit ok;
    ok = (emit_cnt > start);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge hclk);
      if (emit_cnt > start) ok = 1;
    end
    if (!ok) chk("emit_timeout", 0, 1);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_band", out_band, 0);
    chk("rst_frame_last", out_frame_last, 0);
    chk("rst_ovf", ovf_sticky, 0);
  endtask

  task automatic do_reset();
    @(posedge hclk);
    #1;
    rst_n = 0; in_valid = 0;
    #1;
    check_reset_vals();
    @(posedge hclk);
    #1;
    rst_n = 1;
  endtask

  task automatic band_1(input logic [31:0] p, input logic [15:0] w, input logic [31:0] req, input string nm);
    int s;
    s = emit_cnt;
    send_beat(p, w, 1);
    wait_emit(s);
    chk(nm, seen_data, req);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 0; in_valid = 0; in_power = 0; in_weight = 0; in_last = 0;
    repeat (3) @(posedge hclk);
    #1;
    rst_n = 1;
    #1;
    check_reset_vals();

    band_1(32'd1, 16'h8000, 32'h3F80_0000, "single_data");
    chk("single_band", seen_band, 0);
    chk("single_latency", seen_lat, 4);

    s = emit_cnt;
    send_beat(32'd3, 16'h4000, 0);
    send_beat(32'd5, 16'h8000, 1);
    in_valid = 1; in_power = 32'd100; in_weight = 16'h8000; in_last = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      chk("busy_in_ready", in_ready, 0);
    end
    @(posedge hclk);
    #1;
    in_valid = 0; in_last = 0;
    wait_emit(s);
    chk("two_beat_data", seen_data, 32'h40D0_0000);
    chk("two_beat_band", seen_band, 1);

    band_1(32'd0, 16'h8000, 32'h3380_0000, "zero_power");
    band_1(32'd7, 16'h0000, 32'h3380_0000, "zero_weight");

    s = emit_cnt;
    for (int i = 0; i < 257; i++) send_beat(32'hFFFF_FFFF, 16'hFFFF, i == 256);
    wait_emit(s);
    chk("sat_data", seen_data, 32'h53FF_FFFF);
    chk("sat_ovf", seen_ovf, 1);
    band_1(32'd1, 16'h8000, 32'h3F80_0000, "post_sat_data");
    chk("post_sat_ovf", seen_ovf, 1);

    for (int i = 0; i < 3; i++) send_beat(32'd10, 16'h8000, 0);
    do_reset();
    band_1(32'd2, 16'h8000, 32'h4000_0000, "after_reset_data");
    chk("after_reset_band", seen_band, 0);

    do_reset();
    for (int i = 0; i < 27; i++) begin
      band_1(32'd1, 16'h8000, 32'h3F80_0000, "wrap_data");
      chk("wrap_band", seen_band, i % 26);
      chk("wrap_frame_last", seen_fl, i == 25);
    end

    repeat (3) @(posedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
